// File: rtl/clk_period_meter.sv
// clk_period_meter: measures clk_in period in clk_50mhz cycles, with lock and stall detection
module clk_period_meter #(
    parameter int EXP_PERIOD = 500000,
    parameter int TOL        = 500,
    parameter int TIMEOUT    = 1000000,
    parameter int LOCK_CNT   = 4
) (
    input  logic        clk_50mhz,
    input  logic        rst,
    input  logic        clk_in,
    output logic [19:0] period,
    output logic        valid,
    output logic        locked,
    output logic        timeout
);
    localparam int GW = $clog2(LOCK_CNT + 1);
    typedef enum logic {IDLE, MEASURE} state_t;
    state_t        state;
    logic          sync1, sync2, hist;
    logic          edge_p;
    logic [19:0]   cnt, cnt_inc;
    logic [31:0]   diff;
    logic          in_tol;
    logic [GW-1:0] good_cnt, good_next;
    assign edge_p    = sync2 & ~hist;
    assign cnt_inc   = (cnt == 20'hFFFFF) ? cnt : cnt + 20'd1;
    assign diff      = (32'(cnt_inc) >= 32'(EXP_PERIOD)) ? 32'(cnt_inc) - 32'(EXP_PERIOD)
                                                         : 32'(EXP_PERIOD) - 32'(cnt_inc);
    assign in_tol    = diff <= 32'(TOL);
    assign good_next = !in_tol ? '0 : (good_cnt == GW'(LOCK_CNT)) ? good_cnt : good_cnt + GW'(1);
    // two-flop synchronizer followed by a history flop for rising-edge detection
    always_ff @(posedge clk_50mhz or negedge rst) begin
        if (!rst) {sync1, sync2, hist} <= 3'b000;
        else      {sync1, sync2, hist} <= {clk_in, sync1, sync2};
    end
    // measurement FSM: arm on first edge, measure edge-to-edge, drop to IDLE on stall
    always_ff @(posedge clk_50mhz or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            cnt      <= '0;
            good_cnt <= '0;
            period   <= '0;
            valid    <= 1'b0;
            locked   <= 1'b0;
            timeout  <= 1'b0;
        end else begin
            valid <= 1'b0;
            if (state == IDLE) begin
                cnt <= '0;
                if (edge_p) begin
                    state   <= MEASURE;
                    timeout <= 1'b0;
                end
            end else if (edge_p) begin
                period   <= cnt_inc;
                valid    <= 1'b1;
                cnt      <= '0;
                good_cnt <= good_next;
                locked   <= good_next == GW'(LOCK_CNT);
            end else if (cnt == 20'(TIMEOUT - 1)) begin
                state    <= IDLE;
                timeout  <= 1'b1;
                locked   <= 1'b0;
                good_cnt <= '0;
                cnt      <= '0;
            end else begin
                cnt <= cnt_inc;
            end
        end
    end
endmodule

// File: tb/tb_clk_period_meter.sv
// tb_clk_period_meter: directed checks of period, lock, timeout and reset behaviour
module tb_clk_period_meter;
    logic        clk_50mhz = 1'b0;
    logic        rst = 1'b0;
    logic        clk_in = 1'b0;
    logic [19:0] period_a, period_b;
    logic        valid_a, valid_b, locked_a, locked_b, timeout_a, timeout_b;
    int          checks = 0, errors = 0, vcount = 0, dbl = 0, n = 0;
    logic        prev_a = 1'b0, prev_b = 1'b0;

    clk_period_meter #(.EXP_PERIOD(10), .TOL(0), .TIMEOUT(20), .LOCK_CNT(4)) dut_a (
        .clk_50mhz(clk_50mhz), .rst(rst), .clk_in(clk_in),
        .period(period_a), .valid(valid_a), .locked(locked_a), .timeout(timeout_a)
    );
    clk_period_meter #(.EXP_PERIOD(10), .TOL(1), .TIMEOUT(20), .LOCK_CNT(4)) dut_b (
        .clk_50mhz(clk_50mhz), .rst(rst), .clk_in(clk_in),
        .period(period_b), .valid(valid_b), .locked(locked_b), .timeout(timeout_b)
    );

    always #10 clk_50mhz = ~clk_50mhz;

    // count valid pulses and flag any back-to-back valid
    always @(posedge clk_50mhz) begin
        #1;
        if (valid_a) vcount++;
        if ((valid_a && prev_a) || (valid_b && prev_b)) dbl++;
        prev_a = valid_a;
        prev_b = valid_b;
    end

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic cyc(input int k);
        repeat (k) @(negedge clk_50mhz);
    endtask

    task automatic tick(input int k);
        clk_in = 1'b1;
        cyc(k / 2);
        clk_in = 1'b0;
        cyc(k - k / 2);
    endtask

    initial begin
        clk_in = 1'b1;
        cyc(3);
        check("rst_period", period_a, 0);
        check("rst_valid", valid_a, 0);
        check("rst_locked", locked_a, 0);
        check("rst_timeout", timeout_a, 0);
        rst = 1'b1;
        tick(10);
        check("high_at_release_arms_only", vcount, 0);
        for (int i = 0; i < 4; i++) begin
            tick(10);
            check("period_10", period_a, 10);
            check("valid_count", vcount, i + 1);
            check("lock_build", locked_a, i == 3);
        end
        tick(11);
        tick(10);
        check("period_11", period_a, 11);
        check("a_unlock_11", locked_a, 0);
        check("b_keep_lock_11", locked_b, 1);
        for (int i = 0; i < 4; i++) begin
            tick(10);
            check("relock_period", period_a, 10);
            check("relock", locked_a, i == 3);
        end
        n = vcount;
        cyc(12);
        check("no_early_timeout", timeout_a, 0);
        check("locked_before_timeout", locked_a, 1);
        cyc(1);
        check("timeout_set", timeout_a, 1);
        check("timeout_unlocks", locked_a, 0);
        check("timeout_period_held", period_a, 10);
        check("timeout_no_valid", vcount, n);
        cyc(30);
        check("timeout_stays", timeout_b, 1);
        tick(10);
        check("timeout_cleared", timeout_a, 0);
        check("rearm_no_valid", vcount, n);
        tick(20);
        check("after_rearm_period", period_a, 10);
        tick(10);
        check("edge_wins_period", period_a, 20);
        check("edge_wins_no_timeout", timeout_a, 0);
        tick(9);
        tick(10);
        check("period_9_a", period_a, 9);
        check("period_9_b", period_b, 9);
        check("a_unlocked_9", locked_a, 0);
        clk_in = 1'b1;
        cyc(5);
        #3 rst = 1'b0;
        #2;
        check("async_rst_period", period_a, 0);
        check("async_rst_valid", valid_a, 0);
        check("async_rst_locked_b", locked_b, 0);
        check("async_rst_timeout", timeout_a, 0);
        check("async_rst_period_b", period_b, 0);
        #98 rst = 1'b1;
        clk_in = 1'b0;
        cyc(5);
        n = vcount;
        tick(10);
        check("post_rst_arm_only", vcount, n);
        tick(10);
        check("post_rst_period", period_a, 10);
        check("post_rst_locked", locked_a, 0);
        check("post_rst_valid_count", vcount, n + 1);
        cyc(3);
        check("no_double_valid", dbl, 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
